// File: rtl/ddr2_ctrl_pkg.sv
// Shared definitions for the DDR2 controller write path: feeder FSM encoding and default geometry.
package ddr2_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } wr_state_e;

  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DATA_LEVEL = 2;
  localparam int DEF_WBURST_LEN = 8;
  localparam int DEF_FIFO_AW    = 6;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: dout always presents mem[rd_ptr]; a push while full is
// accepted only if a pop happens in the same cycle.
module sync_fifo_sa #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [FIFO_AW:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [FIFO_AW:0]      cnt_q;
  logic                  do_push, do_pop;

  assign count   = cnt_q;
  assign full    = (cnt_q == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !pop;
  assign udf     = pop && empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_feeder.sv
// Write-path feeder: buffers user data, requests bursts from the AXI write master and walks a
// wrapping address window. Define AXI_WR_FEEDER_FLUSH_EN to add the partial-burst flush input.
//
// state | meaning
// IDLE  | waiting for a full burst (or pending flush) with DDR initialised and master idle
// REQ   | wr_trig high for this single cycle
// BUSY  | burst in flight; wr_len/wr_addr held until wr_done
module axi_wr_feeder
  import ddr2_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LEVEL = DEF_DATA_LEVEL,
  parameter int WBURST_LEN = DEF_WBURST_LEN,
  parameter int FIFO_AW    = DEF_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  user_wr_en,
  input  logic [DATA_WIDTH-1:0] user_wr_data,
  output logic                  user_full,
  input  logic [ADDR_WIDTH-1:0] wr_base_addr,
  input  logic [ADDR_WIDTH-1:0] wr_end_addr,
  input  logic                  addr_reload,
  output logic                  wr_trig,
  output logic [7:0]            wr_len,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_en,
  input  logic                  wr_ready,
  input  logic                  wr_done,
  output logic                  overflow,
  output logic                  underflow
`ifdef AXI_WR_FEEDER_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int CW  = FIFO_AW + 1;
  localparam int AW1 = ADDR_WIDTH + 1;

  wr_state_e             state_q, state_d;
  logic [CW-1:0]         fifo_cnt, avail;
  logic                  fifo_full, fifo_empty, fifo_ovf, fifo_udf;
  logic                  push_acc, start_full, start_part;
  logic [7:0]            len_d, wr_len_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, cur_addr, idle_addr;
  logic [AW1-1:0]        next_addr;
  logic                  wrap, reload_pend;
  logic                  unused_empty;

  sync_fifo_sa #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (user_wr_en),
    .pop   (wr_data_en),
    .din   (user_wr_data),
    .dout  (wr_data),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf),
    .udf   (fifo_udf)
  );

  // Emptiness is derived from avail here; the FIFO flag is not needed.
  assign unused_empty = fifo_empty;

  assign user_full  = fifo_full;
  assign wr_len     = wr_len_q;
  assign wr_addr    = wr_addr_q;
  // Threshold counts the word being pushed this cycle.
  assign push_acc   = user_wr_en && !fifo_full;
  assign avail      = fifo_cnt + CW'(push_acc);
  assign start_full = init_end && wr_ready && (avail >= CW'(WBURST_LEN));

`ifdef AXI_WR_FEEDER_FLUSH_EN
  logic flush_pend;

  assign start_part = flush_pend && init_end && wr_ready && (avail != '0) &&
                      (avail < CW'(WBURST_LEN));

  always_ff @(posedge clk) begin
    if (rst)
      flush_pend <= 1'b0;
    else if (flush)
      flush_pend <= 1'b1;
    else if (state_q == ST_IDLE && (state_d == ST_REQ || avail == '0))
      flush_pend <= 1'b0;
  end
`else
  assign start_part = 1'b0;
`endif

  assign len_d     = start_full ? 8'(WBURST_LEN) : 8'(avail);
  assign next_addr = {1'b0, cur_addr} + AW1'(wr_len_q) * AW1'(DATA_LEVEL);
  assign wrap      = (next_addr >= {1'b0, wr_end_addr});
  assign idle_addr = addr_reload ? wr_base_addr : cur_addr;

  always_comb begin
    state_d = state_q;
    wr_trig = 1'b0;
    case (state_q)
      ST_IDLE: if (start_full || start_part) state_d = ST_REQ;
      ST_REQ: begin
        wr_trig = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (wr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_len_q    <= '0;
      wr_addr_q   <= '0;
      cur_addr    <= wr_base_addr;
      reload_pend <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q   <= state_d;
      overflow  <= overflow | fifo_ovf;
      underflow <= underflow | fifo_udf;
      if (state_q == ST_IDLE) begin
        if (addr_reload) cur_addr <= wr_base_addr;
        if (state_d == ST_REQ) begin
          wr_len_q  <= len_d;
          wr_addr_q <= idle_addr;
        end
      end else begin
        // A reload during a burst is held back and replaces the advance at wr_done.
        if (addr_reload) reload_pend <= 1'b1;
        if (state_q == ST_BUSY && wr_done) begin
          reload_pend <= 1'b0;
          if (reload_pend || addr_reload || wrap)
            cur_addr <= wr_base_addr;
          else
            cur_addr <= next_addr[ADDR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_feeder.sv
// Self-checking bench for axi_wr_feeder: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model with a write-master model.
module tb_axi_wr_feeder;
  import ddr2_ctrl_pkg::*;

  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int DL    = 2;
  localparam int BL    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, init_end, user_wr_en, user_full, addr_reload;
  logic [DW-1:0] user_wr_data, wr_data;
  logic [AW-1:0] wr_base_addr, wr_end_addr, wr_addr;
  logic          wr_trig, wr_data_en, wr_ready, wr_done, overflow, underflow, flush;
  logic [7:0]    wr_len;

  always #5 clk = ~clk;

  axi_wr_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .init_end     (init_end),
    .user_wr_en   (user_wr_en),
    .user_wr_data (user_wr_data),
    .user_full    (user_full),
    .wr_base_addr (wr_base_addr),
    .wr_end_addr  (wr_end_addr),
    .addr_reload  (addr_reload),
    .wr_trig      (wr_trig),
    .wr_len       (wr_len),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_data_en   (wr_data_en),
    .wr_ready     (wr_ready),
    .wr_done      (wr_done),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef AXI_WR_FEEDER_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  bit            m_busy, pend_m, ovf_m, prev_trig;
  int            m_left, m_len, n_bursts, exp_len;
  logic [AW-1:0] exp_addr;
  bit            push_req, cons_en, reload_req;
  logic [DW-1:0] push_val;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] end_a;
    int            nwords;
    int            exp_bursts;
    logic [AW-1:0] exp_next;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock of master model + reference model; outputs sampled 1 ns after the edge.
  task automatic step();
    bit            popping, full_m, in_flight;
    logic [AW:0]   adv;
    wr_data_en   = 1'b0;
    wr_done      = 1'b0;
    wr_ready     = !m_busy;
    user_wr_en   = push_req;
    user_wr_data = push_val;
    addr_reload  = reload_req;
    in_flight    = m_busy || (wr_trig === 1'b1);
    if (wr_trig === 1'b1) begin
      n_bursts++;
      chk("trig_single_cycle", 64'(prev_trig), 0);
      chk("trig_while_master_busy", 64'(m_busy), 0);
      chk("burst_len", wr_len, exp_len);
      chk("burst_addr", wr_addr, exp_addr);
      chk("burst_in_window", 64'(wr_addr < wr_end_addr), 1);
      chk("burst_data_buffered", 64'(q.size() >= int'(wr_len)), 1);
    end
    if (m_busy && m_left > 0 && cons_en) begin
      wr_data_en = 1'b1;
      if (q.size() > 0) chk("wr_data", wr_data, q[0]);
      else begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_data: pop requested with reference queue empty, got 0x%0h", wr_data);
      end
    end else if (m_busy && m_left == 0) begin
      wr_done = 1'b1;
    end
    full_m  = (q.size() >= DEPTH);
    popping = wr_data_en && (q.size() > 0);
    if (popping) void'(q.pop_front());
    if (wr_data_en) m_left--;
    if (push_req) begin
      if (!full_m || popping) q.push_back(push_val);
      else ovf_m = 1'b1;
    end
    if (reload_req) begin
      if (in_flight) pend_m = 1'b1;
      else exp_addr = wr_base_addr;
    end
    if (wr_done) begin
      adv = {1'b0, exp_addr} + (AW + 1)'(m_len * DL);
      exp_addr = (pend_m || adv >= {1'b0, wr_end_addr}) ? wr_base_addr : adv[AW-1:0];
      pend_m = 1'b0;
      m_busy = 1'b0;
    end
    if (wr_trig === 1'b1) begin
      m_busy = 1'b1;
      m_left = int'(wr_len);
      m_len  = int'(wr_len);
    end
    prev_trig = (wr_trig === 1'b1);
    @(posedge clk);
    #1;
    reload_req = 1'b0;
    chk("user_full", 64'(user_full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(overflow), 64'(ovf_m));
  endtask

  task automatic do_reset(input logic [AW-1:0] b, input logic [AW-1:0] e);
    wr_base_addr = b;
    wr_end_addr  = e;
    rst          = 1'b1;
    user_wr_en   = 1'b0;
    wr_data_en   = 1'b0;
    wr_done      = 1'b0;
    wr_ready     = 1'b1;
    addr_reload  = 1'b0;
    flush        = 1'b0;
    push_req     = 1'b0;
    reload_req   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_busy    = 1'b0;
    m_left    = 0;
    m_len     = 0;
    exp_addr  = b;
    pend_m    = 1'b0;
    ovf_m     = 1'b0;
    prev_trig = 1'b0;
    n_bursts  = 0;
    exp_len   = BL;
    cons_en   = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) begin
      push_req = 1'b1;
      push_val = first + DW'(i);
      step();
    end
    push_req = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base: 26'h100, end_a: 26'h200, nwords: 8,  exp_bursts: 1, exp_next: 26'h110};
    tbl[1] = '{base: 26'h000, end_a: 26'h020, nwords: 40, exp_bursts: 5, exp_next: 26'h010};
    tbl[2] = '{base: 26'h040, end_a: 26'h080, nwords: 7,  exp_bursts: 0, exp_next: 26'h040};
    tbl[3] = '{base: 26'h000, end_a: 26'h040, nwords: 24, exp_bursts: 3, exp_next: 26'h030};

    init_end = 1'b0;
    push_val = '0;
    exp_len  = BL;

    // Directed table: single burst, wrap, below-threshold residue, multi-burst
    for (int v = 0; v < 4; v++) begin
      do_reset(tbl[v].base, tbl[v].end_a);
      if (v == 0) begin
        chk("rst_wr_trig", 64'(wr_trig), 0);
        chk("rst_wr_len", wr_len, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_user_full", 64'(user_full), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_underflow", 64'(underflow), 0);
        chk("rst_count", dut.fifo_cnt, 0);
        chk("rst_state", dut.state_q, ST_IDLE);
        chk("rst_cur_addr", dut.cur_addr, tbl[v].base);
      end
      init_end = 1'b1;
      push_words(tbl[v].nwords, 32'hA0);
      run(100);
      chk("tbl_bursts", n_bursts, tbl[v].exp_bursts);
      chk("tbl_cur_addr", dut.cur_addr, tbl[v].exp_next);
      chk("tbl_master_idle", 64'(m_busy), 0);
    end

    // Init gating
    do_reset(26'h0, 26'h100);
    init_end = 1'b0;
    push_words(16, 32'h10);
    run(10);
    chk("init_low_no_trig", n_bursts, 0);
    init_end = 1'b1;
    run(80);
    chk("init_high_bursts", n_bursts, 2);

    // Full / overflow with no consumer
    do_reset(26'h0, 26'h1000);
    init_end = 1'b0;
    push_words(64, 32'h0);
    chk("full_after_64", 64'(user_full), 1);
    chk("no_ovf_at_64", 64'(overflow), 0);
    push_words(1, 32'd64);
    chk("ovf_after_65", 64'(overflow), 1);
    chk("count_stays_64", dut.fifo_cnt, 64);
    init_end = 1'b1;
    run(250);
    chk("drain_bursts", n_bursts, 8);
    chk("ovf_sticky", 64'(overflow), 1);
    chk("not_full_after_drain", 64'(user_full), 0);

    // Reset during BUSY after three pops
    do_reset(26'h100, 26'h200);
    init_end = 1'b1;
    push_words(8, 32'h50);
    for (int i = 0; i < 40 && !(m_busy && (m_len - m_left) == 3); i++) step();
    chk("reached_three_pops", 64'(m_busy && (m_len - m_left) == 3), 1);
    rst = 1'b1;
    wr_data_en = 1'b0;
    user_wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_wr_trig", 64'(wr_trig), 0);
    chk("midrst_count", dut.fifo_cnt, 0);
    chk("midrst_state", dut.state_q, ST_IDLE);
    chk("midrst_cur_addr", dut.cur_addr, 26'h100);
    do_reset(26'h100, 26'h200);
    init_end = 1'b1;
    push_words(7, 32'h60);
    run(20);
    chk("midrst_seven_no_req", n_bursts, 0);
    push_words(1, 32'h67);
    run(30);
    chk("midrst_eighth_req", n_bursts, 1);

    // Underflow: pop on empty FIFO
    chk("udf_clear", 64'(underflow), 0);
    wr_data_en = 1'b1;
    @(posedge clk);
    #1;
    wr_data_en = 1'b0;
    chk("udf_set", 64'(underflow), 1);
    step();
    chk("udf_sticky", 64'(underflow), 1);

`ifdef AXI_WR_FEEDER_FLUSH_EN
    do_reset(26'h100, 26'h200);
    init_end = 1'b1;
    push_words(5, 32'hC0);
    run(5);
    chk("flush_none_before", n_bursts, 0);
    exp_len = 5;
    flush = 1'b1;
    step();
    flush = 1'b0;
    run(30);
    chk("flush_bursts", n_bursts, 1);
    chk("flush_cur_addr", dut.cur_addr, 26'h10A);
`endif

    // Randomized traffic against the reference model
    for (int ep = 0; ep < 3; ep++) begin
      logic [AW-1:0] b, e;
      b = AW'(16 * $urandom_range(0, 8));
      e = b + AW'(16 * $urandom_range(1, 4));
      do_reset(b, e);
      init_end = 1'b1;
      for (int c = 0; c < 400; c++) begin
        push_req   = ($urandom_range(0, 99) < 55);
        push_val   = $urandom;
        cons_en    = ($urandom_range(0, 3) != 0);
        reload_req = ($urandom_range(0, 99) < 3);
        step();
      end
      push_req = 1'b0;
      cons_en  = 1'b1;
      run(120);
      chk("rand_master_idle", 64'(m_busy), 0);
      chk("rand_residual_below_burst", 64'(q.size() < BL), 1);
      chk("rand_underflow", 64'(underflow), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
